// File: rtl/tm1638_responder.sv
// TM1638-compatible serial slave: receives command/data frames from a
// controller, maintains 16 bytes of display RAM plus display control, and
// shifts a 32-bit key-scan snapshot back out on DIO during key reads.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | STB high or no frame yet; waiting for STB to fall
// S_CMD     | shifting in the first (command) byte of a frame
// S_WRITE   | shifting in data bytes, each stored at the RAM pointer
// S_READ    | driving key snapshot bits on CLK falling edges
// S_DISCARD | rest of frame ignored until STB rises
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_tm1638_clk,
  input  logic         i_tm1638_stb,
  input  logic         i_tm1638_dio,
  output logic         o_tm1638_dio,
  output logic         o_tm1638_dio_oe,
  input  logic [31:0]  i_key_state,
  output logic [127:0] o_disp_ram,
  output logic         o_display_on,
  output logic [2:0]   o_brightness,
  output logic         o_ram_wr,
  output logic [3:0]   o_ram_addr,
  output logic         o_key_read_done,
  output logic         o_proto_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ,
    S_DISCARD
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] clk_sync, stb_sync, dio_sync;
  logic                   clk_prev, stb_prev;
  logic                   clk_s, stb_s, dio_s;
  logic                   clk_rise, clk_fall, stb_rise, stb_fall;

  // After reset the synchronizers hold their reset value of 1; a low STB
  // only counts as a new frame once the chain has flushed and STB has been
  // seen high, so a frame interrupted by reset is never resumed.
  logic [SYNC_STAGES:0]   flush_sr;
  logic                   armed;

  logic [2:0]   bit_cnt;
  logic [6:0]   shift_q;
  logic [7:0]   byte_val;
  logic [3:0]   ptr;
  logic         fixed_addr;
  logic [31:0]  snap;
  logic [5:0]   rd_cnt;
  logic [5:0]   rise_cnt;
  logic         oe_q;

  logic         shift_en, cnt_clr, cmd_done, wr_done, err, rd_drive, rd_rise;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign dio_s    = dio_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev;
  assign clk_fall = ~clk_s & clk_prev;
  assign stb_rise = stb_s & ~stb_prev;
  assign stb_fall = ~stb_s & stb_prev & armed;
  assign byte_val = {dio_s, shift_q};

  // The output enable is released combinationally so DIO is freed in the
  // very cycle the STB rising edge is recognised.
  assign o_tm1638_dio_oe = oe_q & ~stb_rise;

  // Pin synchronizers, edge-detect history and post-reset arming.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clk_sync <= '1;
      stb_sync <= '1;
      dio_sync <= '1;
      clk_prev <= 1'b1;
      stb_prev <= 1'b1;
      flush_sr <= '0;
      armed    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_tm1638_clk};
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], i_tm1638_stb};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], i_tm1638_dio};
      clk_prev <= clk_s;
      stb_prev <= stb_s;
      flush_sr <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
      armed    <= armed | (flush_sr[SYNC_STAGES] & stb_s);
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    cmd_done  = 1'b0;
    wr_done   = 1'b0;
    err       = 1'b0;
    rd_drive  = 1'b0;
    rd_rise   = 1'b0;
    if (stb_rise) begin
      state_nxt = S_IDLE;
      err       = ((state == S_CMD) || (state == S_WRITE)) && (bit_cnt != 3'd0);
    end else if (stb_s) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (stb_fall) begin
            state_nxt = S_CMD;
            cnt_clr   = 1'b1;
          end
        end
        S_CMD: begin
          if (clk_rise) begin
            shift_en = 1'b1;
            if (bit_cnt == 3'd7) begin
              cmd_done = 1'b1;
              case (byte_val[7:6])
                2'b01:   state_nxt = byte_val[1] ? S_READ : S_DISCARD;
                2'b11:   state_nxt = S_WRITE;
                2'b10:   state_nxt = S_DISCARD;
                default: begin
                  state_nxt = S_DISCARD;
                  err       = 1'b1;
                end
              endcase
            end
          end
        end
        S_WRITE: begin
          if (clk_rise) begin
            shift_en = 1'b1;
            wr_done  = (bit_cnt == 3'd7);
          end
        end
        S_READ: begin
          rd_drive = clk_fall;
          rd_rise  = clk_rise;
        end
        default: ;
      endcase
    end
  end

  // State register and datapath: shifter, RAM, display control, key readout.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      bit_cnt         <= '0;
      shift_q         <= '0;
      ptr             <= '0;
      fixed_addr      <= 1'b0;
      snap            <= '0;
      rd_cnt          <= '0;
      rise_cnt        <= '0;
      oe_q            <= 1'b0;
      o_tm1638_dio    <= 1'b0;
      o_disp_ram      <= '0;
      o_display_on    <= 1'b0;
      o_brightness    <= '0;
      o_ram_wr        <= 1'b0;
      o_ram_addr      <= '0;
      o_key_read_done <= 1'b0;
      o_proto_err     <= 1'b0;
    end else begin
      state           <= state_nxt;
      o_ram_wr        <= 1'b0;
      o_key_read_done <= 1'b0;
      o_proto_err     <= err;

      if (cnt_clr || (state_nxt == S_IDLE)) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shift_q <= byte_val[7:1];
      end

      if (cmd_done) begin
        case (byte_val[7:6])
          2'b01: begin
            fixed_addr <= byte_val[2];
            if (byte_val[1]) begin
              snap     <= i_key_state;
              rd_cnt   <= '0;
              rise_cnt <= '0;
            end
          end
          2'b11: ptr <= byte_val[3:0];
          2'b10: begin
            o_display_on <= byte_val[3];
            o_brightness <= byte_val[2:0];
          end
          default: ;
        endcase
      end

      if (wr_done) begin
        o_disp_ram[{ptr, 3'b000} +: 8] <= byte_val;
        o_ram_wr   <= 1'b1;
        o_ram_addr <= ptr;
        if (!fixed_addr) begin
          ptr <= ptr + 4'd1;
        end
      end

      if (rd_drive) begin
        oe_q         <= 1'b1;
        o_tm1638_dio <= rd_cnt[5] ? 1'b0 : snap[rd_cnt[4:0]];
        if (!rd_cnt[5]) begin
          rd_cnt <= rd_cnt + 6'd1;
        end
      end
      if (rd_rise && !rise_cnt[5]) begin
        rise_cnt <= rise_cnt + 6'd1;
        if (rise_cnt == 6'd31) begin
          o_key_read_done <= 1'b1;
        end
      end

      if (state_nxt != S_READ) begin
        oe_q         <= 1'b0;
        o_tm1638_dio <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// Bit-bangs TM1638 frames into the responder and compares its RAM, display
// control, pulses and key readout against a frame-level reference model.
module tb_tm1638_responder;

  localparam int H = 6;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_tm1638_clk, i_tm1638_stb, i_tm1638_dio;
  logic         o_tm1638_dio, o_tm1638_dio_oe;
  logic [31:0]  i_key_state;
  logic [127:0] o_disp_ram;
  logic         o_display_on;
  logic [2:0]   o_brightness;
  logic         o_ram_wr;
  logic [3:0]   o_ram_addr;
  logic         o_key_read_done, o_proto_err;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_tm1638_clk(i_tm1638_clk), .i_tm1638_stb(i_tm1638_stb),
    .i_tm1638_dio(i_tm1638_dio), .o_tm1638_dio(o_tm1638_dio),
    .o_tm1638_dio_oe(o_tm1638_dio_oe), .i_key_state(i_key_state),
    .o_disp_ram(o_disp_ram), .o_display_on(o_display_on),
    .o_brightness(o_brightness), .o_ram_wr(o_ram_wr),
    .o_ram_addr(o_ram_addr), .o_key_read_done(o_key_read_done),
    .o_proto_err(o_proto_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_ram [16];
  logic [3:0] m_ptr;
  logic       m_fixed, m_on;
  logic [2:0] m_bright;
  logic [3:0] exp_addr [$];
  int         exp_err;

  // observed pulses
  logic [3:0] got_addr [$];
  int         got_err, got_done;

  // Record every pulse output as it occurs.
  always @(posedge i_clk) begin
    if (o_ram_wr) got_addr.push_back(o_ram_addr);
    if (o_proto_err) got_err++;
    if (o_key_read_done) got_done++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  function automatic logic [127:0] m_pack();
    logic [127:0] r;
    for (int a = 0; a < 16; a++) r[a*8 +: 8] = m_ram[a];
    return r;
  endfunction

  task automatic m_reset();
    for (int a = 0; a < 16; a++) m_ram[a] = 8'h00;
    m_ptr = 0; m_fixed = 0; m_on = 0; m_bright = 0;
  endtask

  // Frame-level interpretation of a command plus its data bytes.
  task automatic m_frame(input logic [7:0] q[$]);
    logic [7:0] c;
    c = q[0];
    case (c[7:6])
      2'b01: m_fixed = c[2];
      2'b11: begin
        m_ptr = c[3:0];
        for (int i = 1; i < q.size(); i++) begin
          m_ram[m_ptr] = q[i];
          exp_addr.push_back(m_ptr);
          if (!m_fixed) m_ptr = m_ptr + 4'd1;
        end
      end
      2'b10: begin m_on = c[3]; m_bright = c[2:0]; end
      default: exp_err++;
    endcase
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      i_tm1638_clk = 1'b0;
      i_tm1638_dio = b[i];
      cyc(H);
      i_tm1638_clk = 1'b1;
      cyc(H);
    end
  endtask

  task automatic send_frame(input logic [7:0] q[$]);
    i_tm1638_stb = 1'b0;
    cyc(H);
    foreach (q[i]) send_bits(q[i], 8);
    cyc(H);
    i_tm1638_stb = 1'b1;
    cyc(3 * H);
    m_frame(q);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ram"}, o_disp_ram, m_pack());
    chk({tag, "_on"}, o_display_on, m_on);
    chk({tag, "_bright"}, o_brightness, m_bright);
    chk({tag, "_err"}, got_err, exp_err);
    chk({tag, "_nwr"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      chk({tag, "_addr"}, got_addr[i], exp_addr[i]);
    got_addr.delete();
    exp_addr.delete();
  endtask

  task automatic key_read(input string tag, input logic [31:0] key);
    logic [7:0] rb;
    i_key_state = key;
    got_done = 0;
    i_tm1638_stb = 1'b0;
    cyc(H);
    send_bits(8'h42, 8);
    m_fixed = 1'b0;
    i_key_state = ~key;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 8; k++) begin
        i_tm1638_clk = 1'b0;
        cyc(H);
        if (j == 0 && k == 0) chk({tag, "_oe"}, o_tm1638_dio_oe, 1'b1);
        rb[k] = o_tm1638_dio;
        i_tm1638_clk = 1'b1;
        cyc(H);
      end
      chk({tag, "_byte"}, rb, key[j*8 +: 8]);
    end
    chk({tag, "_done"}, got_done, 1);
    i_tm1638_clk = 1'b0;
    cyc(H);
    chk({tag, "_tail"}, o_tm1638_dio, 1'b0);
    i_tm1638_clk = 1'b1;
    cyc(H);
    chk({tag, "_oe_hold"}, o_tm1638_dio_oe, 1'b1);
    i_tm1638_stb = 1'b1;
    cyc(H);
    chk({tag, "_oe_drop"}, o_tm1638_dio_oe, 1'b0);
    chk({tag, "_done_once"}, got_done, 1);
    cyc(2 * H);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int n;
    i_rst_n = 1'b0;
    i_tm1638_clk = 1'b1;
    i_tm1638_stb = 1'b1;
    i_tm1638_dio = 1'b1;
    i_key_state = 32'h0;
    got_err = 0; got_done = 0; exp_err = 0;
    m_reset();
    cyc(4);
    chk("rst_ram", o_disp_ram, 128'h0);
    chk("rst_oe", o_tm1638_dio_oe, 1'b0);
    chk("rst_dio", o_tm1638_dio, 1'b0);
    chk("rst_ctl", {o_display_on, o_brightness}, 4'h0);
    chk("rst_pulses", {o_ram_wr, o_key_read_done, o_proto_err, o_ram_addr}, 7'h0);
    i_rst_n = 1'b1;
    cyc(10);

    q = '{8'h40};                   send_frame(q);
    q = '{8'hC0, 8'h11, 8'h22, 8'h33}; send_frame(q);
    check_state("autoinc");
    q = '{8'hCF, 8'hAA, 8'hBB};     send_frame(q);
    check_state("wrap");
    q = '{8'h44};                   send_frame(q);
    q = '{8'hC5, 8'h01, 8'h02};     send_frame(q);
    check_state("fixed");
    q = '{8'h8D};                   send_frame(q);
    check_state("dispctl");
    q = '{8'h80 | 8'($urandom_range(0, 15))}; send_frame(q);
    check_state("dispctl_rnd");

    key_read("key", 32'h8001_4002);
    key_read("key_rnd", $urandom);
    check_state("after_key");

    q = '{8'h20, 8'hC0, 8'h55};     send_frame(q);
    check_state("invalid");
    i_tm1638_stb = 1'b0;
    cyc(H);
    send_bits(8'hC3, 8);
    send_bits(8'h5A, 4);
    i_tm1638_stb = 1'b1;
    cyc(3 * H);
    m_ptr = 4'h3;
    exp_err++;
    check_state("partial");

    for (int it = 0; it < 12; it++) begin
      q = '{8'h40 | (8'($urandom_range(0, 1)) << 2)};
      send_frame(q);
      q = '{8'hC0 | 8'($urandom_range(0, 15))};
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        q.push_back(b);
      end
      send_frame(q);
      check_state("rnd");
    end

    i_tm1638_stb = 1'b0;
    cyc(H);
    send_bits(8'hC0, 8);
    send_bits(8'hFF, 3);
    i_rst_n = 1'b0;
    cyc(3);
    m_reset();
    exp_addr.delete();
    chk("midrst_ram", o_disp_ram, 128'h0);
    chk("midrst_outs", {o_display_on, o_brightness, o_tm1638_dio_oe, o_tm1638_dio,
                        o_ram_wr, o_key_read_done, o_proto_err}, 9'h0);
    i_rst_n = 1'b1;
    cyc(4 * H);
    i_tm1638_clk = 1'b1;
    i_tm1638_stb = 1'b1;
    cyc(3 * H);
    q = '{8'hC0, 8'($urandom), 8'($urandom)};
    send_frame(q);
    check_state("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
